spi_cmd_master: RTL and testbench

Host-side SPI master that turns single-byte RAM commands into the serial frames consumed by the SPI slave + RAM wrapper, and captures read-back bytes from MISO. Sits directly upstream of the wrapper: drives SS_n/MOSI, samples MISO, all on the shared system clk (no separate SCLK). Exposes a valid/ready command port and a one-cycle response strobe to the host/testbench driver.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_cmd_master_if.sv | 25 ++
 rtl/spi_shift_unit.sv | 57 +++++
 rtl/spi_cmd_master.sv | 149 ++++++++++++++
 tb/tb_spi_cmd_master.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI command master.
package spi_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_RECV,
        ST_END
    } spi_state_e;

    // Serial frame = 2 opcode bits followed by the payload.
    function automatic int unsigned frame_bits(input int unsigned addr_size);
        return addr_size + 2;
    endfunction

    // Counter must reach the longest phase length minus one.
    function automatic int unsigned cnt_bits(input int unsigned addr_size,
                                             input int unsigned rd_gap,
                                             input int unsigned idle_gap);
        int unsigned span;
        span = addr_size + 4;
        if (rd_gap + 1 > span) span = rd_gap + 1;
        if (idle_gap + 1 > span) span = idle_gap + 1;
        return $clog2(span);
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Host command/response port plus the serial lines to the SPI slave wrapper.
interface spi_cmd_master_if #(
    parameter int unsigned ADDR_SIZE = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_SIZE-1:0] cmd_data;
    logic                 rsp_valid;
    logic [ADDR_SIZE-1:0] rsp_data;
    logic                 busy;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );
endinterface

// File: rtl/spi_shift_unit.sv
// TX parallel-load shift register, RX serial-in shift register and phase counter.
module spi_shift_unit #(
    parameter int unsigned FRAME_W = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_frame,
    input  logic               shift_en,
    input  logic               sample_en,
    input  logic               miso,
    input  logic               cnt_clr,
    input  logic               cnt_inc,
    output logic               tx_msb,
    output logic [DATA_W-1:0]  rx_next,
    output logic [CNT_W-1:0]   cnt
);
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state for the shift registers and counter.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        rx_next = {rx_q[DATA_W-2:0], miso};
        if (load)
            tx_d = load_frame;
        else if (shift_en)
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        if (sample_en)
            rx_d = rx_next;
        if (cnt_clr)
            cnt_d = '0;
        else if (cnt_inc)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Register update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

    assign tx_msb = tx_q[FRAME_W-1];
    assign cnt    = cnt_q;
endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI master: serialises one command frame per accept, captures read bytes.
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned RD_GAP    = 1,
    parameter int unsigned IDLE_GAP  = 1
) (
    input logic              clk,
    input logic              rst,
    spi_cmd_master_if.master bus
);
    localparam int unsigned ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam int unsigned FRAME_W   = frame_bits(ADDR_SIZE);
    localparam int unsigned CNT_W     = cnt_bits(ADDR_SIZE, RD_GAP, IDLE_GAP);
    localparam int unsigned GAP_CYC   = (RD_GAP == 0) ? 1 : RD_GAP;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(ADDR_SIZE - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(IDLE_GAP - 1);

    spi_state_e           state_q, state_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                 is_read_q, is_read_d;

    logic                 load, shift_en, sample_en, cnt_clr, cnt_inc;
    logic                 tx_msb;
    logic [ADDR_SIZE-1:0] rx_next;
    logic [CNT_W-1:0]     cnt;

    spi_shift_unit #(
        .FRAME_W (FRAME_W),
        .DATA_W  (ADDR_SIZE),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_frame ({bus.cmd_op, bus.cmd_data}),
        .shift_en   (shift_en),
        .sample_en  (sample_en),
        .miso       (bus.MISO),
        .cnt_clr    (cnt_clr),
        .cnt_inc    (cnt_inc),
        .tx_msb     (tx_msb),
        .rx_next    (rx_next),
        .cnt        (cnt)
    );

    // Next-state, counter control and registered-output values.
    // Outputs are derived from the state being entered so the flops line up with it.
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        load        = 1'b0;
        shift_en    = 1'b0;
        sample_en   = 1'b0;
        cnt_clr     = 1'b1;
        cnt_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = ST_SEL;
                    load      = 1'b1;
                    is_read_d = (spi_op_e'(bus.cmd_op) == OP_RD_DATA);
                end
            end
            ST_SEL: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt == SHIFT_LAST) state_d = ST_HOLD;
                else begin cnt_clr = 1'b0; cnt_inc = 1'b1; end
            end
            ST_HOLD: begin
                if (!is_read_q)       state_d = ST_END;
                else if (RD_GAP == 0) state_d = ST_RECV;
                else                  state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_d = ST_RECV;
                else begin cnt_clr = 1'b0; cnt_inc = 1'b1; end
            end
            ST_RECV: begin
                sample_en = 1'b1;
                if (cnt == RECV_LAST) begin
                    state_d     = ST_END;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            ST_END: begin
                if (cnt == END_LAST) state_d = ST_IDLE;
                else begin cnt_clr = 1'b0; cnt_inc = 1'b1; end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_SEL: begin
                ss_n_d = 1'b0;
                mosi_d = bus.cmd_op[1];
            end
            ST_SHIFT: begin
                ss_n_d   = 1'b0;
                mosi_d   = tx_msb;
                shift_en = 1'b1;
            end
            ST_HOLD, ST_GAP, ST_RECV: ss_n_d = 1'b0;
            default: ;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            is_read_q   <= is_read_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: frame-level reference model, SPI slave/RAM responder,
// directed command sequences with literal expectations.
module tb_spi_cmd_master;
    localparam int unsigned ADDR_SIZE = 8;
    localparam int unsigned RD_GAP    = 1;
    localparam int unsigned IDLE_GAP  = 1;

    logic clk;
    logic rst;

    spi_cmd_master_if #(.ADDR_SIZE(ADDR_SIZE)) bus();

    spi_cmd_master #(
        .MEM_DEPTH (256),
        .RD_GAP    (RD_GAP),
        .IDLE_GAP  (IDLE_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one queue entry per expected cycle ----------------
    typedef struct {
        logic       ss;
        logic       mosi;
        logic       rsp;
        logic       commit;
        logic [1:0] op;
        logic [7:0] data;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_wa, m_ra, m_rsp_data;

    function automatic ent_t mk(input logic ss, input logic mo, input logic rs,
                                input logic cm, input logic [1:0] op, input logic [7:0] d);
        ent_t e;
        e.ss = ss; e.mosi = mo; e.rsp = rs; e.commit = cm; e.op = op; e.data = d;
        return e;
    endfunction

    task automatic push_frame(input logic [1:0] op, input logic [7:0] d);
        logic [9:0] f;
        logic [7:0] rd;
        f  = {op, d};
        rd = m_mem[m_ra];
        q.push_back(mk(1'b0, op[1], 1'b0, 1'b0, op, d));
        for (int i = 9; i >= 0; i--) q.push_back(mk(1'b0, f[i], 1'b0, 1'b0, op, d));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, op, d));
        if (op == 2'b11) begin
            for (int i = 0; i < int'(RD_GAP); i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, op, d));
            for (int i = 0; i < 8; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, op, d));
        end
        for (int i = 0; i < int'(IDLE_GAP); i++)
            q.push_back(mk(1'b1, 1'b0, (op == 2'b11) && (i == 0), 1'b0, op,
                           (op == 2'b11) ? rd : d));
    endtask

    initial m_rsp_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rsp_data = '0;
        end else begin
            if (q.size() != 0) begin
                void'(q.pop_front());
            end else if (bus.cmd_valid) begin
                push_frame(bus.cmd_op, bus.cmd_data);
            end
            if (q.size() != 0) begin
                if (q[0].commit) begin
                    case (q[0].op)
                        2'b00:   m_wa = q[0].data;
                        2'b01:   m_mem[m_wa] = q[0].data;
                        2'b10:   m_ra = q[0].data;
                        default: ;
                    endcase
                end
                if (q[0].rsp) m_rsp_data = q[0].data;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() != 0) begin
                check("SS_n", bus.SS_n, q[0].ss);
                check("MOSI", bus.MOSI, q[0].mosi);
                check("rsp_valid", bus.rsp_valid, q[0].rsp);
                check("cmd_ready", bus.cmd_ready, 1'b0);
                check("busy", bus.busy, 1'b1);
            end else begin
                check("SS_n_idle", bus.SS_n, 1'b1);
                check("MOSI_idle", bus.MOSI, 1'b0);
                check("rsp_valid_idle", bus.rsp_valid, 1'b0);
                check("cmd_ready_idle", bus.cmd_ready, 1'b1);
                check("busy_idle", bus.busy, 1'b0);
            end
            check("rsp_data", bus.rsp_data, m_rsp_data);
        end
    end

    // ---------------- SPI slave + RAM responder, frame monitor ----------------
    int         s_k = 0;
    int         last_low = 0;
    int         frames_seen = 0;
    logic [9:0] s_frame, s_last_rx;
    logic [11:0] s_seq;
    logic [1:0] s_op;
    logic [7:0] s_wa, s_ra, s_byte;
    logic [7:0] s_mem [256];

    initial begin
        bus.MISO = 1'b0;
        s_op     = 2'b00;
        forever begin
            @(negedge clk);
            if (rst || bus.SS_n) begin
                if (s_k > 0) begin
                    last_low = s_k;
                    frames_seen++;
                end
                s_k      = 0;
                bus.MISO = 1'b0;
            end else begin
                s_k++;
                if (s_k == 1) s_seq = '0;
                if (s_k <= 12) s_seq = {s_seq[10:0], bus.MOSI};
                if (s_k >= 2 && s_k <= 11) s_frame = {s_frame[8:0], bus.MOSI};
                if (s_k == 12) begin
                    s_last_rx = s_frame;
                    s_op      = s_frame[9:8];
                    case (s_frame[9:8])
                        2'b00: s_wa = s_frame[7:0];
                        2'b01: s_mem[s_wa] = s_frame[7:0];
                        2'b10: s_ra = s_frame[7:0];
                        default: s_byte = s_mem[s_ra];
                    endcase
                end
                if (s_op == 2'b11 && s_k >= 13 + int'(RD_GAP) && s_k <= 20 + int'(RD_GAP))
                    bus.MISO = s_byte[7 - (s_k - 13 - int'(RD_GAP))];
                else
                    bus.MISO = 1'b0;
            end
        end
    end

    int gaps[$];
    int g = 0;
    int rsp_pulses = 0;

    initial forever begin
        @(negedge clk);
        if (rst) g = 0;
        else begin
            if (bus.rsp_valid) rsp_pulses++;
            if (bus.busy && bus.SS_n) g++;
            else if (!bus.busy && g > 0) begin
                gaps.push_back(g);
                g = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit keep_valid);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        wait_ready("accept");
        @(negedge clk);
        if (!keep_valid) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        wait_ready("idle");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_gaps(input string nm);
        while (gaps.size() != 0) check(nm, gaps.pop_front(), IDLE_GAP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    int f0;
    int p0;

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        #12;
        check("rst_SS_n", bus.SS_n, 1'b1);
        check("rst_MOSI", bus.MOSI, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        @(posedge clk); #2 rst = 1'b0;
        repeat (20) @(negedge clk);

        // wr_addr 0x3C: bit-exact frame, 12 cycles low
        send(2'b00, 8'h3C, 1'b0);
        wait_idle();
        check("wr_addr_mosi_seq", s_seq, 12'b000001111000);
        check("wr_addr_low_len", last_low, 12);
        check("wr_addr_rx_data", s_last_rx, 10'h03C);
        check_gaps("wr_addr_gap");

        // write 0xA5, read it back
        p0 = rsp_pulses;
        send(2'b01, 8'hA5, 1'b0);
        wait_idle();
        send(2'b10, 8'h3C, 1'b0);
        wait_idle();
        check("no_rsp_for_writes", rsp_pulses - p0, 0);
        send(2'b11, 8'h00, 1'b0);
        wait_idle();
        check("rd_low_len", last_low, 12 + RD_GAP + 8);
        check("rd_rsp_pulses", rsp_pulses - p0, 1);
        check("rd_rsp_data", bus.rsp_data, 8'hA5);
        check_gaps("rd_gap");

        // four commands with cmd_valid held high throughout
        f0 = frames_seen;
        p0 = rsp_pulses;
        send(2'b00, 8'h10, 1'b1);
        send(2'b01, 8'h5A, 1'b1);
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b0);
        wait_idle();
        check("b2b_frames", frames_seen - f0, 4);
        check("b2b_rsp_pulses", rsp_pulses - p0, 1);
        check("b2b_rsp_data", bus.rsp_data, 8'h5A);
        check_gaps("b2b_gap");

        // cmd_valid pulse during a frame must be ignored
        f0 = frames_seen;
        send(2'b00, 8'h77, 1'b0);
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'hFF;
        check("busy_ready_low", bus.cmd_ready, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("busy_frames", frames_seen - f0, 1);
        send(2'b01, 8'h11, 1'b0);
        wait_idle();
        check_gaps("busy_gap");

        // asynchronous reset at L6 of a wr_data frame
        p0 = rsp_pulses;
        send(2'b01, 8'hC3, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_SS_n", bus.SS_n, 1'b1);
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_low_len", last_low, 5);
        send(2'b00, 8'h01, 1'b0);
        wait_idle();
        check("post_rst_mosi_seq", s_seq, 12'b000000000010);
        check("post_rst_rx_data", s_last_rx, 10'h001);
        send(2'b10, 8'h77, 1'b0);
        wait_idle();
        send(2'b11, 8'h00, 1'b0);
        wait_idle();
        check("post_rst_rsp_pulses", rsp_pulses - p0, 1);
        check("post_rst_rsp_data", bus.rsp_data, 8'h11);
        check_gaps("post_rst_gap");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
